// File: rtl/prga_fifo_pkg.sv
// Shared definitions for the PRGA FIFO adapters: the occupancy-state type
// used by the lookahead-to-non-lookahead buffer and its encoding width.
package prga_fifo_pkg;

    // Width of the occupancy-state encoding
    localparam int COUNT_WIDTH = 2;

    // Number of words held in the 2-entry buffer
    typedef enum logic [COUNT_WIDTH-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } count_e;

endpackage : prga_fifo_pkg

// File: rtl/fifo_lookahead_to_nl_buffer.sv
// Adapts an upstream lookahead (first-word-fall-through) FIFO to a downstream
// non-lookahead interface: data appears on dout the cycle after an accepted rd
// and stays there until the next accepted rd. A 2-entry buffer decouples the
// upstream pop from the downstream read, so rd never reaches rd_i combinationally
// and one word per cycle is sustained.
// Optional feature: define PRGA_FIFO_UNDERFLOW_FLAG_EN to add a sticky
// underflow output, set by any rd seen while empty and cleared only by rst.
module fifo_lookahead_to_nl_buffer
    import prga_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // upstream lookahead FIFO
    input  logic                  empty_i,
    output logic                  rd_i,
    input  logic [DATA_WIDTH-1:0] dout_i,
    // downstream non-lookahead interface
    output logic                  empty,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout
`ifdef PRGA_FIFO_UNDERFLOW_FLAG_EN
    ,
    output logic                  underflow
`endif
);

    count_e                count;
    count_e                count_next;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    logic [DATA_WIDTH-1:0] slot0_next;
    logic [DATA_WIDTH-1:0] slot1_next;
    logic                  push;
    logic                  pop;

    // NOTE: rst is folded into rd_i so the upstream FIFO is never popped while
    // reset is held, even though the state register already reads EMPTY.
    assign rd_i  = !rst && !empty_i && (count != TWO);
    assign push  = rd_i;
    assign pop   = rd && (count != EMPTY);
    assign empty = (count == EMPTY);

    // Next occupancy and slot contents; a same-cycle pop frees slot0 before the push lands
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // through the case can infer a latch.
        count_next = count;
        slot0_next = slot0;
        slot1_next = slot1;
        case (count)
            EMPTY: begin
                if (push) begin
                    count_next = ONE;
                    slot0_next = dout_i;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        count_next = TWO;
                        slot1_next = dout_i;
                    end
                    2'b01: begin
                        count_next = EMPTY;
                    end
                    2'b11: begin
                        // old head leaves on dout, new word becomes head
                        slot0_next = dout_i;
                    end
                    default: ;
                endcase
            end
            TWO: begin
                // push is impossible here because rd_i is low in TWO
                if (pop) begin
                    count_next = ONE;
                    slot0_next = slot1;
                end
            end
            default: begin
                count_next = EMPTY;
            end
        endcase
    end

    // State, buffer slots and the held output word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data slots and dout are reset too, so the outputs are
            // deterministic (dout=0) during and right after reset.
            count <= EMPTY;
            slot0 <= '0;
            slot1 <= '0;
            dout  <= '0;
        end else begin
            count <= count_next;
            slot0 <= slot0_next;
            slot1 <= slot1_next;
            if (pop) begin
                dout <= slot0;
            end
        end
    end

`ifdef PRGA_FIFO_UNDERFLOW_FLAG_EN
    // Sticky flag for any read attempted while the buffer is empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (rd && (count == EMPTY)) begin
            underflow <= 1'b1;
        end
    end
`endif

endmodule : fifo_lookahead_to_nl_buffer

// File: tb/tb_fifo_lookahead_to_nl_buffer.sv
// Self-checking bench for fifo_lookahead_to_nl_buffer. A queue-based model of
// the buffer (at most two words, pop before push) predicts rd_i, empty, dout
// and, with PRGA_FIFO_UNDERFLOW_FLAG_EN, underflow; a compare process checks
// them every cycle. Directed phases pin the model with literal expectations.
`timescale 1ns/1ps
module tb_fifo_lookahead_to_nl_buffer;

    localparam int DW = 8;
    typedef logic [DW-1:0] data_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  empty_i;
    logic  rd_i;
    data_t dout_i;
    logic  empty;
    logic  rd;
    data_t dout;
`ifdef PRGA_FIFO_UNDERFLOW_FLAG_EN
    logic  underflow;
`endif

    fifo_lookahead_to_nl_buffer #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .empty_i (empty_i),
        .rd_i    (rd_i),
        .dout_i  (dout_i),
        .empty   (empty),
        .rd      (rd),
        .dout    (dout)
`ifdef PRGA_FIFO_UNDERFLOW_FLAG_EN
        ,
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    bit    check_en = 0;

    // upstream FIFO contents and the buffer model
    data_t src[$];
    data_t mq[$];
    data_t m_dout;
    bit    m_uf;
    logic  last_rd_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_uf   = 1'b0;
    endtask

    // Buffer behaviour on one rising edge: a read takes the oldest word, an
    // upstream word is accepted whenever one is offered and fewer than two are held.
    task automatic model_update();
        bit push_m;
        bit pop_m;
        if (rst) begin
            model_reset();
        end else begin
            push_m = !empty_i && (mq.size() < 2);
            pop_m  = rd && (mq.size() > 0);
            if (rd && mq.size() == 0) m_uf = 1'b1;
            if (pop_m) m_dout = mq.pop_front();
            if (push_m) mq.push_back(dout_i);
        end
    endtask

    // One clock cycle: drive inputs after the edge, sample rd_i mid-cycle,
    // advance the model on the edge and pop the upstream FIFO if rd_i was high.
    task automatic cycle(input logic rd_v, input logic avail);
        rd = rd_v;
        if (avail && src.size() > 0) begin
            empty_i = 1'b0;
            dout_i  = src[0];
        end else begin
            empty_i = 1'b1;
            dout_i  = data_t'($urandom);
        end
        @(negedge clk);
        last_rd_i = rd_i;
        @(posedge clk);
        model_update();
        #1;
        if (last_rd_i && src.size() > 0) void'(src.pop_front());
    endtask

    // Per-cycle comparison of all outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && check_en) begin
                check("rd_i", {31'd0, rd_i}, {31'd0, (!empty_i && (mq.size() < 2))});
                check("empty", {31'd0, empty}, {31'd0, (mq.size() == 0)});
                check("dout", 32'(dout), 32'(m_dout));
`ifdef PRGA_FIFO_UNDERFLOW_FLAG_EN
                check("underflow", {31'd0, underflow}, {31'd0, m_uf});
`endif
            end
        end
    end

    initial begin
        int   pulses;
        logic bp[4];

        // reset with an upstream word already offered
        rst     = 1'b1;
        rd      = 1'b0;
        src.push_back(8'hA5);
        empty_i = 1'b0;
        dout_i  = 8'hA5;
        model_reset();
        #3;
        check("reset_rd_i", {31'd0, rd_i}, 32'd0);
        check("reset_empty", {31'd0, empty}, 32'd1);
        check("reset_dout", 32'(dout), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        check_en = 1;

        // single word: one upstream pop, then one read
        pulses = 0;
        cycle(1'b0, 1'b1);
        pulses += int'(last_rd_i);
        check("single_empty_fall", {31'd0, empty}, 32'd0);
        cycle(1'b0, 1'b1);
        pulses += int'(last_rd_i);
        cycle(1'b0, 1'b1);
        pulses += int'(last_rd_i);
        check("single_rd_i_pulses", 32'(pulses), 32'd1);
        cycle(1'b1, 1'b1);
        check("single_dout", 32'(dout), 32'hA5);
        check("single_empty_after", {31'd0, empty}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        check("single_dout_held", 32'(dout), 32'hA5);
`ifdef PRGA_FIFO_UNDERFLOW_FLAG_EN
        check("underflow_clear", {31'd0, underflow}, 32'd0);
`endif

        // underflow: reads while empty leave dout alone
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        check("underflow_dout", 32'(dout), 32'hA5);
        cycle(1'b0, 1'b1);
`ifdef PRGA_FIFO_UNDERFLOW_FLAG_EN
        check("underflow_sticky", {31'd0, underflow}, 32'd1);
`endif

        // backpressure: rd_i high for two cycles, then low until a read
        for (int i = 0; i < 4; i++) src.push_back(data_t'(8'h30 + i));
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1);
            bp[i] = last_rd_i;
        end
        check("bp_rd_i_0", {31'd0, bp[0]}, 32'd1);
        check("bp_rd_i_1", {31'd0, bp[1]}, 32'd1);
        check("bp_rd_i_2", {31'd0, bp[2]}, 32'd0);
        check("bp_rd_i_3", {31'd0, bp[3]}, 32'd0);
        cycle(1'b1, 1'b1);
        check("bp_rd_i_full", {31'd0, last_rd_i}, 32'd0);
        check("bp_dout", 32'(dout), 32'h30);
        cycle(1'b0, 1'b1);
        check("bp_rd_i_reassert", {31'd0, last_rd_i}, 32'd1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1);
        check("bp_drain_dout", 32'(dout), 32'h33);
        check("bp_drain_empty", {31'd0, empty}, 32'd1);

        // streaming: one word per cycle with rd held high
        for (int i = 1; i <= 16; i++) src.push_back(data_t'(i));
        cycle(1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b1, 1'b1);
            check("stream_dout", 32'(dout), 32'(k));
        end
        cycle(1'b0, 1'b1);
        check("stream_empty_end", {31'd0, empty}, 32'd1);

        // reset mid-stream with two words buffered
        for (int i = 0; i < 6; i++) src.push_back(data_t'(8'h40 + i));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        check("pre_reset_rd_i", {31'd0, rd_i}, 32'd0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst_rd_i", {31'd0, rd_i}, 32'd0);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check("midrst_dout", 32'(dout), 32'd0);
        cycle(1'b0, 1'b1);
        rst = 1'b0;
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        check("post_reset_first_word", 32'(dout), 32'h42);
`ifdef PRGA_FIFO_UNDERFLOW_FLAG_EN
        check("post_reset_underflow", {31'd0, underflow}, 32'd0);
`endif

        // random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            while (src.size() < 4) src.push_back(data_t'($urandom));
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        check("random_drained", {31'd0, empty}, 32'd1);

        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fifo_lookahead_to_nl_buffer
